// File: rtl/lea_ctr_controller.sv
// rtl/lea_ctr_controller.sv - CTR-mode sequencer around one LEA block core.
// Optional WAIT_ENC watchdog with error output: define LEA_CTR_TIMEOUT_EN.
module lea_ctr_controller #(
  parameter int CTR_WIDTH      = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         iv,
  input  logic [LEN_WIDTH-1:0] num_blocks,
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [127:0]         s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [127:0]         m_data,
  input  logic                 lea_key_ready,
  output logic                 lea_rq_data,
  output logic [127:0]         lea_block_i,
  input  logic                 lea_done,
  input  logic [127:0]         lea_block_o
`ifdef LEA_CTR_TIMEOUT_EN
  ,
  output logic                 error
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    REQ,
    WAIT_ENC,
    WAIT_DATA,
    OUTPUT,
    DONE,
    ABORT
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state_q, state_d;
  logic [127:0]         ctr_q, ctr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [127:0]         ks_q, ks_d;
  logic [127:0]         mdat_q, mdat_d;
  logic [127:0]         blk_q, blk_d;
  logic [CTR_WIDTH-1:0] ctr_lo_inc;

`ifdef LEA_CTR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d       = (state_q == WAIT_ENC) ? wd_q + WD_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign error = (state_q == ABORT);
`endif

  // Only the low counter bits roll over; the nonce bits above never see a carry.
  assign ctr_lo_inc = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    ks_d    = ks_q;
    mdat_d  = mdat_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_blocks == '0) begin
            state_d = DONE;
          end else begin
            ctr_d   = iv;
            rem_d   = num_blocks;
            state_d = WAIT_KEY;
          end
        end
      end
      WAIT_KEY: begin
        if (lea_key_ready) state_d = REQ;
      end
      REQ: begin
        blk_d   = ctr_q;
        state_d = WAIT_ENC;
      end
      WAIT_ENC: begin
        if (lea_done) begin
          ks_d    = lea_block_o;
          state_d = WAIT_DATA;
        end
`ifdef LEA_CTR_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = ABORT;
        end
`endif
      end
      WAIT_DATA: begin
        if (s_valid) begin
          mdat_d  = s_data ^ ks_q;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          ctr_d[CTR_WIDTH-1:0] = ctr_lo_inc;
          rem_d                = rem_q - LEN_WIDTH'(1);
          state_d              = (rem_q == LEN_WIDTH'(1)) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      rem_q   <= '0;
      ks_q    <= '0;
      mdat_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      ks_q    <= ks_d;
      mdat_q  <= mdat_d;
      blk_q   <= blk_d;
    end
  end

  assign busy        = (state_q != IDLE) && (state_q != DONE) && (state_q != ABORT);
  assign done        = (state_q == DONE) || (state_q == ABORT);
  assign s_ready     = (state_q == WAIT_DATA);
  assign m_valid     = (state_q == OUTPUT);
  assign m_data      = mdat_q;
  assign lea_rq_data = (state_q == REQ);
  // The core sees the live counter during REQ, then the held copy until the next request.
  assign lea_block_i = (state_q == REQ) ? ctr_q : blk_q;

endmodule

// File: tb/tb_lea_ctr_controller.sv
// tb/tb_lea_ctr_controller.sv - directed bench for lea_ctr_controller with a model LEA core.
// Core model returns ctr ^ K three cycles after each request; define LEA_CTR_TIMEOUT_EN to test the watchdog.
module tb_lea_ctr_controller;

  localparam logic [127:0] K  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] S2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] iv = '0;
  logic [15:0]  num_blocks = '0;
  logic         busy, done;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         lea_key_ready = 1'b0;
  logic         lea_rq_data;
  logic [127:0] lea_block_i;
  logic         lea_done = 1'b0;
  logic [127:0] lea_block_o = '0;
  logic         error;

  always #5 clk = ~clk;

  lea_ctr_controller dut (
    .clk(clk), .rst(rst), .start(start), .iv(iv), .num_blocks(num_blocks),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .lea_key_ready(lea_key_ready), .lea_rq_data(lea_rq_data), .lea_block_i(lea_block_i),
    .lea_done(lea_done), .lea_block_o(lea_block_o)
`ifdef LEA_CTR_TIMEOUT_EN
    , .error(error)
`endif
  );

`ifndef LEA_CTR_TIMEOUT_EN
  assign error = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core model and transfer monitor, evaluated mid-cycle.
  logic         core_en = 1'b1;
  int           lat = 0;
  logic [127:0] pend = '0;
  int           rq_cnt = 0, out_cnt = 0, done_cnt = 0;
  logic [127:0] rq_log [0:7];
  logic [127:0] out_log[0:7];

  always @(negedge clk) begin
    lea_done = 1'b0;
    if (rst) begin
      lat = 0;
    end else begin
      if (lat > 0) begin
        lat--;
        if (lat == 0 && core_en) begin
          lea_done    = 1'b1;
          lea_block_o = pend ^ K;
        end
      end
      if (lea_rq_data) begin
        if (rq_cnt < 8) rq_log[rq_cnt] = lea_block_i;
        rq_cnt++;
        pend = lea_block_i;
        lat  = 3;
      end
      if (m_valid && m_ready) begin
        if (out_cnt < 8) out_log[out_cnt] = m_data;
        out_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  int   cyc, first_rq;
  logic busy_d, err_d;

  task automatic clear_logs();
    rq_cnt = 0; out_cnt = 0; done_cnt = 0;
  endtask

  task automatic start_job(input logic [127:0] v, input logic [15:0] n);
    @(posedge clk); #1;
    clear_logs();
    iv = v; num_blocks = n; start = 1'b1;
    cyc = 0; first_rq = -1;
  endtask

  task automatic wait_done(input int limit);
    busy_d = 1'b1; err_d = 1'b0;
    while (cyc < limit) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (first_rq < 0 && lea_rq_data) first_rq = cyc;
      if (done) begin
        busy_d = busy; err_d = error;
        return;
      end
    end
    chk("done_within_bound", done, 1'b1);
  endtask

  logic [127:0] iv_w, iv_b, held;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rq", lea_rq_data, 0);
    chk("rst_block_i", lea_block_i, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;

    // Basic three-block job across a carry out of the low byte.
    lea_key_ready = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = '0;
    start_job(128'h0FF, 16'd3);
    wait_done(200);
    chk("basic_first_rq_lat", first_rq, 2);
    chk("basic_done_cycle", cyc, 20);
    chk("basic_busy_at_done", busy_d, 0);
    chk("basic_err_at_done", err_d, 0);
    @(posedge clk); #1;
    chk("basic_rq_cnt", rq_cnt, 3);
    chk("basic_out_cnt", out_cnt, 3);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_rq0", rq_log[0], 128'h0FF);
    chk("basic_rq1", rq_log[1], 128'h100);
    chk("basic_rq2", rq_log[2], 128'h101);
    chk("basic_out0", out_log[0], 128'h0FF ^ K);
    chk("basic_out1", out_log[1], 128'h100 ^ K);
    chk("basic_out2", out_log[2], 128'h101 ^ K);

    // Low counter word wraps without touching the nonce.
    iv_w = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFFFFFF};
    start_job(iv_w, 16'd2);
    wait_done(200);
    chk("wrap_rq0", rq_log[0], iv_w);
    chk("wrap_rq1", rq_log[1], {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h00000000});
    chk("wrap_out1", out_log[1], {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'h00000000} ^ K);

    // Key expansion held off for 50 cycles.
    lea_key_ready = 1'b0;
    start_job(128'h77, 16'd1);
    repeat (50) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("key_no_rq", rq_cnt, 0);
    chk("key_busy", busy, 1);
    lea_key_ready = 1'b1;
    @(posedge clk); #1;
    cyc++;
    chk("key_rq_next", lea_rq_data, 1);
    wait_done(100);
    chk("key_out0", out_log[0], 128'h77 ^ K);

    // Output backpressure plus a start that must be ignored.
    s_data = S2; m_ready = 1'b0;
    iv_b = 128'h11111111_22222222_33333333_00000010;
    start_job(iv_b, 16'd2);
    while (!m_valid && cyc < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("bp_m_valid_seen", m_valid, 1);
    held = m_data;
    chk("bp_first_data", held, S2 ^ iv_b ^ K);
    iv = 128'h5555; num_blocks = 16'd9; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_data", m_data, held);
    end
    chk("bp_no_new_rq", rq_cnt, 1);
    m_ready = 1'b1;
    cyc = 0;
    wait_done(100);
    @(posedge clk); #1;
    chk("bp_rq_cnt", rq_cnt, 2);
    chk("bp_rq1", rq_log[1], iv_b + 128'd1);
    chk("bp_out1", out_log[1], S2 ^ (iv_b + 128'd1) ^ K);
    chk("bp_done_cnt", done_cnt, 1);

    // Zero-length job.
    start_job(128'h1234, 16'd0);
    wait_done(5);
    chk("zero_done_cycle", cyc, 1);
    chk("zero_busy", busy_d, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_rq", rq_cnt, 0);

    // Reset while holding a block in OUTPUT.
    m_ready = 1'b0;
    start_job(128'h99, 16'd2);
    while (!m_valid && cyc < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("mid_m_valid_seen", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_m_valid", m_valid, 0);
    chk("mid_m_data", m_data, 0);
    chk("mid_block_i", lea_block_i, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt, 0);
    chk("mid_idle", busy, 0);
    start_job(128'h5, 16'd1);
    wait_done(100);
    chk("mid_fresh_busy", busy_d, 0);
    @(posedge clk); #1;
    chk("mid_fresh_out", out_log[0], S2 ^ 128'h5 ^ K);

`ifdef LEA_CTR_TIMEOUT_EN
    // Core never answers: watchdog aborts the job.
    core_en = 1'b0;
    start_job(128'h42, 16'd1);
    wait_done(1200);
    chk("tmo_cycle", cyc, 1027);
    chk("tmo_error", err_d, 1);
    chk("tmo_busy", busy_d, 0);
    @(posedge clk); #1;
    chk("tmo_error_pulse", error, 0);
    core_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
